// File: rtl/leaf_stream_pkg.sv
// leaf_stream_pkg: shared defaults, depth check helper and transfer struct for leaf_stream_fifo.
package leaf_stream_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef struct packed {
        logic push;
        logic pop;
    } xfer_t;

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/leaf_stream_ram.sv
// leaf_stream_ram: DEPTH x WIDTH register array, one write port and an asynchronous read port.
module leaf_stream_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/leaf_stream_fifo.sv
// leaf_stream_fifo: valid/ready stream FIFO with registered in_ready and fill count.
// Define LEAF_FIFO_AF_EN to add the registered almost_full output (threshold AF_LEVEL).
module leaf_stream_fifo
    import leaf_stream_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH)
`ifdef LEAF_FIFO_AF_EN
    ,
    parameter int AF_LEVEL = DEPTH - 1
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W:0]   count
`ifdef LEAF_FIFO_AF_EN
    ,
    output logic              almost_full
`endif
);

    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("leaf_stream_fifo: DEPTH must be a power of two >= 2");
    end

    xfer_t             x;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic [WIDTH-1:0]  rdata;

    // Flush wins: a handshake in the flush cycle is dropped rather than stored.
    always_comb begin
        x.push     = in_valid & in_ready_q & ~flush;
        x.pop      = out_valid & out_ready & ~flush;
        wr_ptr_d   = flush ? '0 : wr_ptr_q + ADDR_W'(x.push);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + ADDR_W'(x.pop);
        count_d    = flush ? '0 : count_q + (ADDR_W + 1)'(x.push) - (ADDR_W + 1)'(x.pop);
        in_ready_d = count_d < FULL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    always @(posedge clk) begin
        if (!rst) assert (count_q <= FULL);
    end

    leaf_stream_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (x.push),
        .waddr(wr_ptr_q),
        .wdata(in_data),
        .raddr(rd_ptr_q),
        .rdata(rdata)
    );

    // Storage is not reset, so the head is masked to zero while empty.
    assign out_valid = count_q != '0;
    assign out_data  = out_valid ? rdata : '0;
    assign in_ready  = in_ready_q;
    assign count     = count_q;

`ifdef LEAF_FIFO_AF_EN
    logic almost_full_q, almost_full_d;

    always_comb begin
        almost_full_d = count_d >= (ADDR_W + 1)'(AF_LEVEL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) almost_full_q <= 1'b0;
        else     almost_full_q <= almost_full_d;
    end

    assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// tb_leaf_stream_fifo: directed self-checking bench for leaf_stream_fifo (WIDTH=8, DEPTH=4).
module tb_leaf_stream_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] count;
`ifdef LEAF_FIFO_AF_EN
    logic       almost_full;
`endif

    int total = 0;
    int bad = 0;

    leaf_stream_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count)
`ifdef LEAF_FIFO_AF_EN
        ,
        .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got %0d want 0", count); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got %h want 00", out_data); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; in_data = 8'h00;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_out_valid got %b want 1", out_valid); end
        total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_out_data got %h want a5", out_data); end
        total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got %0d want 1", count); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (out_data !== 8'hA5 || count !== 3'd1) begin bad++; $display("FAIL single_hold%0d got %h/%0d want a5/1", i, out_data, count); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL single_pop got count %0d valid %b want 0/0", count, out_valid); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            tick();
`ifdef LEAF_FIFO_AF_EN
            total++; if (almost_full !== (i >= 3)) begin bad++; $display("FAIL fill_af%0d got %b want %b", i, almost_full, i >= 3); end
`endif
        end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_count got %0d want 4", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        in_data = 8'h05;
        tick();
        in_valid = 1'b0;
        total++; if (count !== 3'd4 || out_data !== 8'h01) begin bad++; $display("FAIL fill_ignored got %0d/%h want 4/01", count, out_data); end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            total++; if (out_data !== 8'(i) || out_valid !== 1'b1) begin bad++; $display("FAIL drain_data%0d got %h want %h", i, out_data, 8'(i)); end
            tick();
            if (i == 1) begin
                total++; if (in_ready !== 1'b1 || count !== 3'd3) begin bad++; $display("FAIL drain_ready_after_full got %b/%0d want 1/3", in_ready, count); end
            end
        end
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL drain_empty got %b/%0d want 0/0", out_valid, count); end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h10;
        tick();
        total++; if (count !== 3'd1) begin bad++; $display("FAIL b2b_first_count got %0d want 1", count); end
        for (int i = 1; i < 20; i++) begin
            in_data = 8'(8'h10 + i);
            total++; if (out_data !== 8'(8'h10 + i - 1)) begin bad++; $display("FAIL b2b_order%0d got %h want %h", i, out_data, 8'(8'h10 + i - 1)); end
            tick();
            total++; if (count !== 3'd1) begin bad++; $display("FAIL b2b_count%0d got %0d want 1", i, count); end
        end
        in_valid = 1'b0;
        total++; if (out_data !== 8'h23) begin bad++; $display("FAIL b2b_last got %h want 23", out_data); end
        tick();
        out_ready = 1'b0;
        total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got %0d/%b want 0/0", count, out_valid); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h30 + i);
            tick();
        end
        total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_prefill got %0d want 3", count); end
        in_data = 8'h3F; out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        total++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_clear got %0d/%b/%b want 0/0/1", count, out_valid, in_ready); end
`ifdef LEAF_FIFO_AF_EN
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL flush_af got %b want 0", almost_full); end
`endif
        tick();
        total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_discard got %0d/%b want 0/0", count, out_valid); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h40 + i);
            tick();
        end
        in_valid = 1'b0;
`ifdef LEAF_FIFO_AF_EN
        total++; if (almost_full !== 1'b1) begin bad++; $display("FAIL areset_af_pre got %b want 1", almost_full); end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (count !== 3'd2 || out_data !== 8'h41) begin bad++; $display("FAIL areset_pre got %0d/%h want 2/41", count, out_data); end
        #2 rst = 1'b1;
        #1;
        total++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h00) begin bad++; $display("FAIL areset_clear got %0d/%b/%b/%h want 0/0/0/00", count, out_valid, in_ready, out_data); end
`ifdef LEAF_FIFO_AF_EN
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL areset_af got %b want 0", almost_full); end
`endif
        tick();
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL areset_release got %b/%0d want 1/0", in_ready, count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
